// File: rtl/neg_decode_serial.sv
// neg_decode_serial: bit-serial two's-complement to sign-magnitude decoder.
// The operand is accepted through a valid/ready handshake and walked LSB-first,
// one bit per clock. The result is presented as sign + WIDTH-bit magnitude
// through a second valid/ready handshake.
//
// The optional overflow flag is enabled by defining NEG_DECODE_OVF_EN. It adds
// the out_ovf port, which is set when the operand was the most-negative value.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand; in_ready = 1
// SHIFT | converting one bit per clock, LSB first
// DONE  | result valid, held until out_ready
module neg_decode_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_valid,
    input  logic             out_ready
`ifdef NEG_DECODE_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic             seen_one;
    logic [CW-1:0]    cnt;
    logic             ready_q;
    logic             valid_q;

    logic             load;
    logic             step;
    logic             finish;
    logic             pop;
    logic             bit_o;
    logic [WIDTH-1:0] mag_shift;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes for the datapath.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Negative operands: copy bits up to and including the first 1, then invert.
    always_comb begin
        bit_o     = sr[0] ^ (sign & seen_one);
        mag_shift = {bit_o, mag[WIDTH-1:1]};
    end

    // Conversion datapath: shift register, magnitude accumulator, bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            mag      <= '0;
            sign     <= 1'b0;
            seen_one <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            sr       <= in_data;
            mag      <= '0;
            sign     <= in_data[WIDTH-1];
            seen_one <= 1'b0;
            cnt      <= '0;
        end else if (step) begin
            sr       <= sr >> 1;
            mag      <= mag_shift;
            seen_one <= seen_one | sr[0];
            cnt      <= cnt + CW'(1);
        end
    end

    // Handshake flags kept as their own flops so they never glitch on state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            if (load) begin
                ready_q <= 1'b0;
            end else if (pop) begin
                ready_q <= 1'b1;
            end
            if (finish) begin
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef NEG_DECODE_OVF_EN
    logic ovf_q;

    // Only the most-negative operand yields a negative result with magnitude 100..0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (finish) begin
            ovf_q <= sign & (mag_shift == MOST_NEG);
        end else if (pop) begin
            ovf_q <= 1'b0;
        end
    end

    assign out_ovf = ovf_q;
`else
    logic unused_most_neg;
    assign unused_most_neg = ^MOST_NEG;
`endif

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_sign  = sign;
    assign out_mag   = mag;

endmodule
